tanh_share_ctrl: RTL and testbench

// Round-robin controller sharing one Tanh activation unit (start/done handshake) among NUM_REQ dense-layer requesters.

---
 rtl/tanh_share_ctrl.sv | 133 +++++++++++++
 tb/tb_tanh_share_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_share_ctrl.sv
// Round-robin owner arbitration for one shared Tanh unit.
// Issues start, waits for the done rising edge, and runs a hang watchdog.
module tanh_share_ctrl #(
  parameter int NUM_REQ        = 3,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] done_out,
  output logic               tanh_start,
  input  logic               tanh_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]   sel_n, sel_inc;
  logic [IDX_W-1:0]   winner, idx;
  logic               win_ok;
  logic [TW-1:0]      timer, timer_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic               start_n, terr_n, busy_n;
  logic               done_d, cmpl;
  int unsigned        p;

  assign cmpl    = tanh_done & ~done_d;
  assign sel_inc = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  // Scan downward so the nearest set bit at/after rr_ptr wins.
  always_comb begin
    winner = '0;
    win_ok = 1'b0;
    idx    = '0;
    p      = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      idx = IDX_W'(p);
      if (req[idx]) begin
        winner = idx;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    sel_n    = sel;
    done_n   = '0;
    start_n  = 1'b0;
    timer_n  = timer;
    rr_ptr_n = rr_ptr;
    terr_n   = timeout_err;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          grant_n         = '0;
          grant_n[winner] = 1'b1;
          sel_n           = winner;
          start_n         = 1'b1;
          state_n         = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        if (cmpl) begin
          done_n[sel] = 1'b1;
          state_n     = RELEASE;
        end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
          terr_n   = 1'b1;
          grant_n  = '0;
          rr_ptr_n = sel_inc;
          state_n  = IDLE;
        end
      end
      RELEASE: begin
        if (!req[sel]) begin
          grant_n  = '0;
          rr_ptr_n = sel_inc;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      sel         <= '0;
      done_out    <= '0;
      tanh_start  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      timer       <= '0;
      done_d      <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      sel         <= sel_n;
      done_out    <= done_n;
      tanh_start  <= start_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
      rr_ptr      <= rr_ptr_n;
      timer       <= timer_n;
      done_d      <= tanh_done;
    end
  end

endmodule

// File: tb/tb_tanh_share_ctrl.sv
// Scoreboard bench for tanh_share_ctrl.
// Expected grants/completions queued by stimulus, popped by monitors.
module tb_tanh_share_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] sel;
  logic [2:0] done_out;
  logic       tanh_start;
  logic       tanh_done;
  logic       busy;
  logic       timeout_err;

  tanh_share_ctrl #(
    .NUM_REQ(3),
    .IDX_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .grant(grant),
    .sel(sel),
    .done_out(done_out),
    .tanh_start(tanh_start),
    .tanh_done(tanh_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nstart = 0;
  int ndone  = 0;
  int exp_grant[$];
  int exp_done[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Tanh unit model
  int   mdelay;
  bit   never_done;
  bit   manual;
  logic man_done;
  logic mdone;
  int   mcnt;
  int   mhold;
  bit   pend;

  assign tanh_done = manual ? man_done : mdone;

  always @(negedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      mdone <= 1'b0;
      mhold <= 0;
      mcnt  <= 0;
    end else begin
      if (mhold != 0) mhold <= mhold - 1;
      if (mhold == 1) mdone <= 1'b0;
      if (tanh_start && !never_done && !manual) begin
        pend <= 1'b1;
        mcnt <= mdelay - 1;
      end else if (pend) begin
        if (mcnt == 0) begin
          pend  <= 1'b0;
          mdone <= 1'b1;
          mhold <= 3;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot0", int'($onehot0(grant)), 1);
      if (tanh_start) begin
        nstart++;
        if (exp_grant.size() == 0) begin
          chk("start_unexpected", int'(grant), 0);
        end else begin
          int e;
          e = exp_grant.pop_front();
          chk("start_grant", int'(grant), 1 << e);
          chk("start_sel", int'(sel), e);
        end
      end
      if (done_out != 3'b000) begin
        ndone++;
        if (exp_done.size() == 0) begin
          chk("done_unexpected", int'(done_out), 0);
        end else begin
          int e;
          e = exp_done.pop_front();
          chk("done_out", int'(done_out), 1 << e);
          chk("done_sel", int'(sel), e);
          chk("done_grant", int'(grant), 1 << e);
        end
      end
    end
  end

  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (done_out == 3'b000 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (done_out == 3'b000) begin
        chk("serve_wait_expired", t, 0);
      end else begin
        req = req & ~done_out;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, d0;
    rst        = 1'b1;
    req        = 3'b000;
    manual     = 1'b0;
    man_done   = 1'b0;
    never_done = 1'b0;
    mdelay     = 12;
    repeat (3) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_start", int'(tanh_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_terr", int'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // single requester
    s0 = nstart;
    exp_grant.push_back(1);
    exp_done.push_back(1);
    req = 3'b010;
    @(negedge clk);
    chk("t1_start", int'(tanh_start), 1);
    chk("t1_grant", int'(grant), 2);
    chk("t1_sel", int'(sel), 1);
    @(negedge clk);
    chk("t1_start_low", int'(tanh_start), 0);
    chk("t1_busy", int'(busy), 1);
    serve(1);
    @(negedge clk);
    chk("t1_grant_rel", int'(grant), 0);
    chk("t1_busy_rel", int'(busy), 0);
    chk("t1_starts", nstart - s0, 1);

    // all three from rr_ptr=0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s0 = nstart;
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back(i);
      exp_done.push_back(i);
    end
    req = 3'b111;
    serve(3);
    chk("t2_starts", nstart - s0, 3);
    exp_grant.push_back(0);
    exp_done.push_back(0);
    req = 3'b001;
    serve(1);

    // rr_ptr=1 now: owner 2 before 0
    exp_grant.push_back(2);
    exp_done.push_back(2);
    exp_grant.push_back(0);
    exp_done.push_back(0);
    req = 3'b101;
    serve(2);

    // watchdog, rr_ptr=1
    never_done = 1'b1;
    d0 = ndone;
    exp_grant.push_back(1);
    req = 3'b010;
    @(negedge clk);
    chk("t4_start", int'(tanh_start), 1);
    @(negedge clk);
    chk("t4_busy", int'(busy), 1);
    repeat (15) @(negedge clk);
    chk("t4_terr_early", int'(timeout_err), 0);
    chk("t4_grant_held", int'(grant), 2);
    @(negedge clk);
    chk("t4_terr", int'(timeout_err), 1);
    chk("t4_grant_clr", int'(grant), 0);
    chk("t4_busy_clr", int'(busy), 0);
    req = 3'b000;
    @(negedge clk);
    chk("t4_no_done", ndone - d0, 0);
    never_done = 1'b0;
    exp_grant.push_back(1);
    exp_done.push_back(1);
    req = 3'b010;
    serve(1);
    chk("t4_terr_sticky", int'(timeout_err), 1);

    // done held high from prior op, rr_ptr=2
    manual   = 1'b1;
    man_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d0 = ndone;
    exp_grant.push_back(0);
    exp_done.push_back(0);
    req = 3'b001;
    @(negedge clk);
    chk("t5_start", int'(tanh_start), 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) man_done = 1'b0;
      if (c == 10) man_done = 1'b1;
    end
    @(negedge clk);
    chk("t5_latency", int'(done_out), 1);
    req = 3'b000;
    repeat (5) @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("t5_single_done", ndone - d0, 1);
    manual = 1'b0;

    // reset mid-WAIT, rr_ptr=1
    exp_grant.push_back(1);
    req = 3'b010;
    @(negedge clk);
    chk("t6_start", int'(tanh_start), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_grant", int'(grant), 0);
    chk("t6_sel", int'(sel), 0);
    chk("t6_done", int'(done_out), 0);
    chk("t6_start_rst", int'(tanh_start), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_terr", int'(timeout_err), 0);
    req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_grant.push_back(2);
    exp_done.push_back(2);
    req = 3'b100;
    @(negedge clk);
    chk("t6_grant_new", int'(grant), 4);
    serve(1);

    repeat (3) @(negedge clk);
    chk("exp_grant_empty", exp_grant.size(), 0);
    chk("exp_done_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
